// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the PLL reset/lock controller.
// Optional retry limit is enabled with PLL_LOCK_RETRY_LIMIT_EN.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int unsigned DEF_RST_PULSE     = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_LOST_W        = 8;
    localparam int unsigned DEF_MAX_RETRIES   = 8;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return bits_for(m);
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// PLL-side and system-side signals of the lock controller.
// pll_fault exists only when PLL_LOCK_RETRY_LIMIT_EN is defined.
interface pll_lock_ctrl_if #(
    parameter int unsigned LOST_W = 8
);
    logic              pll_locked;
    logic              pll_rst;
    logic              sys_rst;
    logic              ready;
    logic [LOST_W-1:0] lost_cnt;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
    logic              pll_fault;

    modport master (input pll_locked, output pll_rst, sys_rst, ready, lost_cnt, pll_fault);
    modport slave  (output pll_locked, input pll_rst, sys_rst, ready, lost_cnt, pll_fault);
`else
    modport master (input pll_locked, output pll_rst, sys_rst, ready, lost_cnt);
    modport slave  (output pll_locked, input pll_rst, sys_rst, ready, lost_cnt);
`endif
endinterface

// File: rtl/pll_sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module pll_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencing, lock wait with timeout, stability qualification and loss tracking.
// Define PLL_LOCK_RETRY_LIMIT_EN to add MAX_RETRIES and the terminal FAULT state.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_PULSE     = DEF_RST_PULSE,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
`ifdef PLL_LOCK_RETRY_LIMIT_EN
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
`endif
    parameter int unsigned LOST_W        = DEF_LOST_W
) (
    input  logic            refclk,
    input  logic            rst,
    pll_lock_ctrl_if.master bus
);
    localparam int unsigned CW = cnt_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
`ifdef PLL_LOCK_RETRY_LIMIT_EN
    localparam int unsigned RW = bits_for(MAX_RETRIES);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

    logic [RW-1:0] retries;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lk;

    pll_sync2 u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (lk)
    );

    // Outputs are updated together with the state so each reflects the state being entered.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state        <= PLL_RST;
            cnt          <= '0;
            bus.pll_rst  <= 1'b1;
            bus.sys_rst  <= 1'b1;
            bus.ready    <= 1'b0;
            bus.lost_cnt <= '0;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
            retries       <= '0;
            bus.pll_fault <= 1'b0;
`endif
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        bus.pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Lock beats a coincident timeout.
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt         <= '0;
                        bus.pll_rst <= 1'b1;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
                        if (retries == RETRY_LAST) begin
                            state         <= FAULT;
                            bus.pll_fault <= 1'b1;
                        end else begin
                            state   <= PLL_RST;
                            retries <= retries + RW'(1);
                        end
`else
                        state <= PLL_RST;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STABLE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        bus.sys_rst <= 1'b0;
                        bus.ready   <= 1'b1;
`ifdef PLL_LOCK_RETRY_LIMIT_EN
                        retries     <= '0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RUN: begin
                    if (!lk) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        bus.pll_rst <= 1'b1;
                        bus.sys_rst <= 1'b1;
                        bus.ready   <= 1'b0;
                        if (bus.lost_cnt != '1)
                            bus.lost_cnt <= bus.lost_cnt + LOST_W'(1);
                    end
                end

`ifdef PLL_LOCK_RETRY_LIMIT_EN
                FAULT: begin
                    state <= FAULT;
                end
`endif

                default: begin
                    state       <= PLL_RST;
                    cnt         <= '0;
                    bus.pll_rst <= 1'b1;
                    bus.sys_rst <= 1'b1;
                    bus.ready   <= 1'b0;
                end
            endcase
        end
    end
endmodule
